// File: rtl/unpack_pkg.sv
// Shared types for the word unpacker.
// Holds the FSM state encoding and the lane-count sanitiser.
package unpack_pkg;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  // A count of zero or above the lane total means a full beat.
  function automatic int fix_count(
    input int cnt,
    input int lanes
  );
    return (cnt == 0 || cnt > lanes) ? lanes : cnt;
  endfunction

endpackage

// File: rtl/word_unpacker.sv
// Splits one wide bus beat into a stream of words.
// Emits lanes 0..count-1 in order, one per output handshake.
module word_unpacker
  import unpack_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int LANES     = 4,
  parameter int BUS_SIZE  = WORD_SIZE * LANES,
  parameter int CNT_W     = $clog2(LANES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_SIZE-1:0]  in_data,
  input  logic [CNT_W-1:0]     in_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_last
);

  if (BUS_SIZE != WORD_SIZE * LANES ||
      LANES < 2 || LANES > 16) begin : g_param_chk
    $error("word_unpacker: illegal parameters");
  end

  state_e              st_q;
  logic [CNT_W-1:0]    idx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [BUS_SIZE-1:0] bus_q;
  logic                in_acc;
  logic                out_hs;

  assign cnt_d = CNT_W'(fix_count(int'(in_count), LANES));

  assign out_valid = (st_q == EMIT);
  assign out_last  = out_valid &&
                     (idx_q == cnt_q - 1'b1);
  assign out_data  =
    bus_q[int'(idx_q) * WORD_SIZE +: WORD_SIZE];

  // The last lane handing off frees the holding register this cycle.
  assign in_ready = !rst &&
                    (!out_valid || (out_last && out_ready));
  assign in_acc   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      bus_q <= '0;
    end else if (in_acc) begin
      st_q  <= EMIT;
      idx_q <= '0;
      cnt_q <= cnt_d;
      bus_q <= in_data;
    end else if (out_hs) begin
      if (out_last) begin
        st_q <= IDLE;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_word_unpacker.sv
// Bench for word_unpacker: default 32x4 and an 8x3 override.
// A queue of expected words models the unpacking per beat.
module tb_word_unpacker;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] da = '0;
  logic [23:0]  db = '0;
  logic [2:0]   ca = '0;
  logic [1:0]   cb = '0;
  logic         ir_a, ov_a, ol_a;
  logic         ir_b, ov_b, ol_b;
  logic [31:0]  od_a;
  logic [7:0]   od_b;

  always #5 clk = ~clk;

  word_unpacker u_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir_a),
    .in_data(da), .in_count(ca),
    .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .out_last(ol_a)
  );

  word_unpacker #(.WORD_SIZE(8), .LANES(3)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir_b),
    .in_data(db), .in_count(cb),
    .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .out_last(ol_b)
  );

  typedef struct {
    logic [31:0] w;
    logic        l;
  } ent_t;

  ent_t q[$];
  int   errs = 0;
  int   checks = 0;
  logic sel = 1'b0;
  logic rst_prev = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r,
                     input logic iv,
                     input logic [127:0] d,
                     input int c,
                     input logic ordy);
    int L, W, n, cc;
    logic [31:0] m, od;
    logic ov, ir, ol, exp_ir;
    logic [127:0] sh;
    @(negedge clk);
    rst = r;
    in_valid = iv;
    out_ready = ordy;
    da = d;
    db = d[23:0];
    ca = 3'(c);
    cb = 2'(c);
    #1;
    L  = sel ? 3 : 4;
    W  = sel ? 8 : 32;
    m  = sel ? 32'hff : 32'hffff_ffff;
    cc = sel ? (c % 4) : (c % 8);
    ov = sel ? ov_b : ov_a;
    ir = sel ? ir_b : ir_a;
    ol = sel ? ol_b : ol_a;
    od = sel ? {24'b0, od_b} : od_a;
    if (r) begin
      chk("in_ready_rst", {31'b0, ir}, 0);
      if (rst_prev) begin
        chk("out_valid_rst", {31'b0, ov}, 0);
        chk("out_last_rst", {31'b0, ol}, 0);
        chk("out_data_rst", od, 0);
      end
      q.delete();
    end else begin
      exp_ir = (q.size() == 0) ||
               (q.size() == 1 && ordy);
      chk("out_valid", {31'b0, ov},
          {31'b0, q.size() != 0});
      chk("in_ready", {31'b0, ir}, {31'b0, exp_ir});
      if (q.size() != 0) begin
        chk("out_data", od, q[0].w);
        chk("out_last", {31'b0, ol}, {31'b0, q[0].l});
        if (ordy) void'(q.pop_front());
      end
      if (iv && exp_ir) begin
        n = (cc == 0 || cc > L) ? L : cc;
        for (int i = 0; i < n; i++) begin
          sh = d >> (i * W);
          q.push_back('{sh[31:0] & m, i == n - 1});
        end
      end
    end
    rst_prev = r;
  endtask

  task automatic idle(input int k, input logic ordy);
    for (int i = 0; i < k; i++) cyc(0, 0, '0, 0, ordy);
  endtask

  task automatic rnd(input int k);
    logic [127:0] d;
    for (int i = 0; i < k; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      cyc($urandom_range(0, 49) == 0,
          1'($urandom), d,
          int'($urandom_range(0, 7)),
          $urandom_range(0, 3) != 0);
    end
  endtask

  localparam logic [127:0] D0 =
    128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D1 =
    128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa;

  initial begin
    cyc(1, 0, '0, 0, 1);
    cyc(1, 0, '0, 0, 1);
    idle(1, 1);
    cyc(0, 1, D0, 4, 1);
    idle(5, 1);
    cyc(0, 1, D1, 2, 1);
    cyc(0, 1, D0, 3, 1);
    cyc(0, 1, D0, 3, 1);
    idle(4, 1);
    cyc(0, 1, D0, 4, 1);
    idle(1, 1);
    idle(3, 0);
    idle(5, 1);
    cyc(0, 1, D1, 0, 1);
    idle(5, 1);
    cyc(0, 1, D0, 7, 1);
    idle(5, 1);
    cyc(0, 1, D1, 1, 1);
    idle(2, 1);
    cyc(0, 1, D0, 4, 1);
    idle(2, 1);
    cyc(1, 0, '0, 0, 1);
    cyc(0, 1, D1, 4, 1);
    idle(5, 1);
    rnd(300);
    idle(6, 1);
    sel = 1'b1;
    cyc(1, 0, '0, 0, 1);
    cyc(1, 0, '0, 0, 1);
    cyc(0, 1, 128'hccbbaa, 3, 1);
    idle(4, 1);
    cyc(0, 1, 128'h332211, 0, 1);
    cyc(0, 1, 128'h665544, 1, 1);
    idle(4, 1);
    rnd(200);
    idle(5, 1);
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/word_unpacker.md
WORD_UNPACKER -- requirements
Module: word_unpacker

Interface
REQ-001 Parameter WORD_SIZE, default 32: width in bits of one output word.
REQ-002 Parameter LANES, default 4: number of words carried by one input bus beat; legal range 2..16.
REQ-003 Parameter BUS_SIZE, default WORD_SIZE * LANES: input bus width, which SHALL be recomputed when WORD_SIZE or LANES alone is overridden.
REQ-004 Parameter CNT_W, default $clog2(LANES+1): width of the lane count field.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_ready  output  1  unpacker accepts a beat this cycle.
REQ-009 in_data  input  BUS_SIZE  packed words; lane i is bits [i*WORD_SIZE +: WORD_SIZE].
REQ-010 in_count  input  CNT_W  number of valid lanes in the beat (1..LANES); 0 or any value above LANES SHALL be treated as LANES.
REQ-011 out_valid  output  1  output word present.
REQ-012 out_ready  input  1  downstream accepts a word.
REQ-013 out_data  output  WORD_SIZE  current lane.
REQ-014 out_last  output  1  current word is the final valid lane of its beat.

Function
REQ-015 Transfers SHALL occur only on cycles where valid and ready are both high; out_valid, out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-016 The FSM SHALL have exactly two states: IDLE (no beat held) and EMIT (beat held, lane index idx in 0..count-1).
REQ-017 In IDLE, in_ready=1 and out_valid=0; an accepted beat SHALL be registered, idx SHALL be set to 0, and the FSM SHALL move to EMIT.
REQ-018 The first word SHALL be visible on out_data one cycle after acceptance, giving a latency of 1.
REQ-019 In EMIT, out_valid=1 and out_data SHALL equal lane idx; out_last SHALL be 1 exactly when idx = count-1.
REQ-020 On an output handshake with idx < count-1, idx SHALL increment by 1.
REQ-021 On an output handshake with idx = count-1, the FSM SHALL return to IDLE unless a new beat is accepted in the same cycle.
REQ-022 in_ready SHALL equal (state==IDLE) or (out_last and out_ready); this is combinational from out_ready.
REQ-023 Back-to-back beats SHALL lose no cycle: when the last lane and a new beat handshake together, the new beat is loaded, idx=0, and the FSM stays in EMIT.
REQ-024 Lanes at or above count SHALL never be emitted; a count=1 beat SHALL produce one word with out_last=1.
REQ-025 Sustained throughput SHALL be one word per cycle when out_ready is held at 1.

Reset
REQ-026 While rst=1: state=IDLE, idx=0, out_valid=0, out_last=0, out_data=0, in_ready=0.
REQ-027 Reset asserted mid-beat SHALL discard the held beat; no word of that beat SHALL appear after reset deasserts.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-029 Package unpack_pkg SHALL hold the state enum (IDLE, EMIT) and a function that sanitises the count per REQ-010.
REQ-030 The design SHALL be a single module with no sub-modules; the lane select SHALL be an indexed part-select of the held bus register.
REQ-031 An elaboration-time check SHALL fail if BUS_SIZE != WORD_SIZE * LANES or if LANES is outside 2..16.

Verification
REQ-032 Defaults, in_data=128'h44444444_33333333_22222222_11111111, count=4, out_ready=1 -> words 11111111, 22222222, 33333333, 44444444 on cycles 1-4 after acceptance, out_last on the fourth only.
REQ-033 Two beats back-to-back with count=2 then count=3, out_ready=1 -> five consecutive words with no gap and out_last on words 2 and 5.
REQ-034 out_ready held at 0 for 3 cycles on lane 1 -> out_data stable and in_ready=0 throughout; the sequence resumes in order.
REQ-035 count=0 and count=7 (with CNT_W=3) -> each emits 4 words; count=1 -> a single word with out_last=1.
REQ-036 rst pulsed during lane 2 -> out_valid=0 the next cycle, in_ready=1 after deassert, and the next beat is emitted from lane 0.
REQ-037 Instance overridden with only WORD_SIZE=8 and LANES=3 -> BUS_SIZE=24, and an 8-bit 3-lane unpack is correct.
